// File: rtl/frame_writer.sv
// Byte-stream receiver: framed RGB444 pixels in raster order into the 96x64 panel framebuffer.
// Optional FRAME_CHECKSUM_EN adds a trailing XOR checksum byte and a frame_err flag.
module frame_writer #(
  parameter int unsigned COLS      = 96,
  parameter int unsigned ROWS      = 64,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic              clk_25MHz,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [23:0]       buf_wdata,
  output logic [1:0]        buf_wmask,
  output logic              buf_we,
  output logic              busy,
  output logic              frame_done
`ifdef FRAME_CHECKSUM_EN
  ,
  output logic              frame_err
`endif
);

  localparam int unsigned X_W = $clog2(COLS);
  localparam int unsigned Y_W = $clog2(ROWS);

  typedef enum logic [2:0] {IDLE, HI, LO, WR, CHK, DONE} state_t;

  state_t         state;
  logic [X_W-1:0] x;
  logic [Y_W-1:0] y;
  logic [3:0]     r_q;
  logic [3:0]     g_q;
  logic           xfer_c;
  logic           last_col_c;
  logic           last_px_c;
`ifdef FRAME_CHECKSUM_EN
  logic [7:0]     chk;
`endif

  assign xfer_c     = in_valid && in_ready;
  assign last_col_c = (x == X_W'(COLS - 1));
  assign last_px_c  = last_col_c && (y == Y_W'(ROWS - 1));

  // Upper half of the panel shares buffer rows with the lower half; y MSB picks the word half.
  always_ff @(posedge clk_25MHz) begin
    if (!rst_n) begin
      state      <= IDLE;
      x          <= '0;
      y          <= '0;
      r_q        <= '0;
      g_q        <= '0;
      in_ready   <= 1'b1;
      buf_we     <= 1'b0;
      buf_wmask  <= 2'b00;
      buf_addr   <= '0;
      buf_wdata  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef FRAME_CHECKSUM_EN
      chk        <= '0;
      frame_err  <= 1'b0;
`endif
    end else begin
      buf_we     <= 1'b0;
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (xfer_c && (in_data == SYNC_BYTE)) begin
            state <= HI;
            busy  <= 1'b1;
`ifdef FRAME_CHECKSUM_EN
            chk   <= '0;
`endif
          end
        end
        HI: begin
          if (xfer_c) begin
            r_q   <= in_data[7:4];
            g_q   <= in_data[3:0];
            state <= LO;
`ifdef FRAME_CHECKSUM_EN
            chk   <= chk ^ in_data;
`endif
          end
        end
        LO: begin
          if (xfer_c) begin
            buf_we    <= 1'b1;
            buf_addr  <= ADDR_W'(x) + ADDR_W'(COLS) * ADDR_W'(y[Y_W-2:0]);
            buf_wdata <= {r_q, g_q, in_data[7:4], r_q, g_q, in_data[7:4]};
            buf_wmask <= y[Y_W-1] ? 2'b01 : 2'b10;
            in_ready  <= 1'b0;
            state     <= WR;
`ifdef FRAME_CHECKSUM_EN
            chk       <= chk ^ in_data;
`endif
          end
        end
        WR: begin
          if (last_col_c) begin
            x <= '0;
            y <= y + Y_W'(1);
          end else begin
            x <= x + X_W'(1);
          end
          if (last_px_c) begin
`ifdef FRAME_CHECKSUM_EN
            state    <= CHK;
            in_ready <= 1'b1;
`else
            state      <= DONE;
            frame_done <= 1'b1;
            busy       <= 1'b0;
`endif
          end else begin
            state    <= HI;
            in_ready <= 1'b1;
          end
        end
`ifdef FRAME_CHECKSUM_EN
        CHK: begin
          if (xfer_c) begin
            state      <= DONE;
            in_ready   <= 1'b0;
            frame_done <= 1'b1;
            busy       <= 1'b0;
            frame_err  <= (in_data != chk);
          end
        end
`endif
        DONE: begin
          state    <= IDLE;
          in_ready <= 1'b1;
          x        <= '0;
          y        <= '0;
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
